// File: rtl/fixed_point_divider_seq.sv
// rtl/fixed_point_divider_seq.sv - sequential signed fixed-point restoring divider
// Ripple-carry add/subtract: cin=1 turns a+b into a-b via a + ~b + 1.
module fpd_ripple_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] bx;
  logic         carry;

  assign bx = b ^ {W{cin}};

  // Bit-serial carry chain; a running variable keeps the chain free of self-loops on a vector.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ bx[i] ^ carry;
      carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    cout = carry;
  end
endmodule

module fixed_point_divider_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW + 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NW-1:0]    M_POS = {{FRAC{1'b0}}, Q_MAX};
  localparam logic [NW-1:0]    M_NEG = {{FRAC{1'b0}}, Q_MIN};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic             loaded;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] amag, bmag;
  logic             sign;
  logic [WIDTH-1:0] dmag;
  logic [NW-1:0]    num, qm;
  logic [WIDTH:0]   rem, shifted, trial;
  logic             no_borrow;
  logic [CW-1:0]    cnt;

  // Operands are registered on accept; abs and zero-detect then get a cycle of their own.
  assign amag    = opa[WIDTH-1] ? (~opa + ONE) : opa;
  assign bmag    = opb[WIDTH-1] ? (~opb + ONE) : opb;
  assign shifted = {rem[WIDTH-1:0], num[NW-1]};

  fpd_ripple_addsub #(.W(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dmag}),
    .cin  (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !loaded;
        if (loaded) state_nxt = (opb == '0) ? DONE : DIV;
      end
      DIV:  if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring steps, sign fix-up and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded      <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      sign        <= 1'b0;
      dmag        <= '0;
      num         <= '0;
      qm          <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!loaded) begin
            if (in_valid) begin
              opa    <= dividend;
              opb    <= divisor;
              loaded <= 1'b1;
            end
          end else begin
            loaded <= 1'b0;
            sign   <= opa[WIDTH-1] ^ opb[WIDTH-1];
            dmag   <= bmag;
            num    <= {amag, {FRAC{1'b0}}};
            rem    <= '0;
            qm     <= '0;
            cnt    <= CW'(NW - 1);
            if (opb == '0) begin
              quotient    <= opa[WIDTH-1] ? Q_MIN : Q_MAX;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end
        DIV: begin
          rem <= no_borrow ? trial : shifted;
          num <= {num[NW-2:0], 1'b0};
          qm  <= {qm[NW-2:0], no_borrow};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (!sign && qm > M_POS) begin
            quotient <= Q_MAX;
            overflow <= 1'b1;
          end else if (sign && qm > M_NEG) begin
            quotient <= Q_MIN;
            overflow <= 1'b1;
          end else begin
            quotient <= sign ? (~qm[WIDTH-1:0] + ONE) : qm[WIDTH-1:0];
            overflow <= 1'b0;
          end
          div_by_zero <= 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
